// File: rtl/character_action_ctrl.sv
// character_action_ctrl: per-character action sequencer.
// Advances position, facing, animation frame and the attack hitbox once per
// video frame tick, from the decoded move-left / move-right / attack key flags.

module character_action_ctrl #(
    parameter logic [9:0] X_MIN           = 10'd0,
    parameter logic [9:0] X_MAX           = 10'd576,
    parameter logic [9:0] X_START         = 10'd100,
    parameter logic [9:0] STEP            = 10'd2,
    parameter int         FRAMES_PER_ANIM = 4,
    parameter int         ATTACK_FRAMES   = 6,
    parameter int         ACT_FIRST       = 2,
    parameter int         ACT_LAST        = 3,
    parameter int         COOLDOWN_TICKS  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       move_l,
    input  logic       move_r,
    input  logic       attack,
    output logic [9:0] pos_x,
    output logic       facing,
    output logic [1:0] state,
    output logic [2:0] anim_frame,
    output logic       attack_active
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WALK     = 2'd1,
        ST_ATTACK   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam logic [7:0] SUB_LAST    = 8'(FRAMES_PER_ANIM - 1);
    localparam logic [2:0] ATK_LAST    = 3'(ATTACK_FRAMES - 1);
    localparam logic [2:0] ACT_FIRST_F = 3'(ACT_FIRST);
    localparam logic [2:0] ACT_LAST_F  = 3'(ACT_LAST);
    localparam logic [7:0] CD_LOAD     = 8'(COOLDOWN_TICKS);

    state_t     state_q;
    logic [7:0] sub_cnt;
    logic [7:0] cd_cnt;
    logic       attack_q;

    logic [9:0] left_x;
    logic [9:0] right_x;
    logic       attack_edge;
    logic       sub_last;

    // Clamped candidate positions for a one-step move in either direction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        left_x  = pos_x - STEP;
        right_x = pos_x + STEP;
        if (pos_x < X_MIN + STEP) begin
            left_x = X_MIN;
        end
        if (pos_x > X_MAX - STEP) begin
            right_x = X_MAX;
        end
    end

    assign attack_edge = attack & ~attack_q;
    assign sub_last    = (sub_cnt == SUB_LAST);

    assign state = state_q;

    // Hitbox is decoded purely from registers, so it never glitches.
    assign attack_active = (state_q == ST_ATTACK) &&
                           (anim_frame >= ACT_FIRST_F) &&
                           (anim_frame <= ACT_LAST_F);

    // Action FSM: everything holds except on a frame tick; reset wins over tick.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (Reset) begin
            pos_x      <= X_START;
            facing     <= 1'b0;
            state_q    <= ST_IDLE;
            anim_frame <= 3'd0;
            sub_cnt    <= 8'd0;
            cd_cnt     <= 8'd0;
            attack_q   <= 1'b0;
        end else if (frame_tick) begin
            attack_q <= attack;
            case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (attack_edge) begin
                        state_q    <= ST_ATTACK;
                        anim_frame <= 3'd0;
                        sub_cnt    <= 8'd0;
                    end else if (move_l ^ move_r) begin
                        state_q <= ST_WALK;
                        facing  <= move_l;
                        pos_x   <= move_l ? left_x : right_x;
                        if (state_q == ST_WALK) begin
                            // Walk cycle loops over four frames; a direction
                            // change keeps the current phase.
                            if (sub_last) begin
                                sub_cnt    <= 8'd0;
                                anim_frame <= {1'b0, anim_frame[1:0] + 2'd1};
                            end else begin
                                sub_cnt <= sub_cnt + 8'd1;
                            end
                        end else begin
                            anim_frame <= 3'd0;
                            sub_cnt    <= 8'd0;
                        end
                    end else begin
                        state_q    <= ST_IDLE;
                        anim_frame <= 3'd0;
                        sub_cnt    <= 8'd0;
                    end
                end
                ST_ATTACK: begin
                    if (sub_last) begin
                        sub_cnt <= 8'd0;
                        if (anim_frame == ATK_LAST) begin
                            anim_frame <= 3'd0;
                            if (COOLDOWN_TICKS == 0) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_COOLDOWN;
                                cd_cnt  <= CD_LOAD;
                            end
                        end else begin
                            anim_frame <= anim_frame + 3'd1;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                ST_COOLDOWN: begin
                    // The tick that sees a count of one is the last lockout tick.
                    if (cd_cnt <= 8'd1) begin
                        state_q <= ST_IDLE;
                        cd_cnt  <= 8'd0;
                    end else begin
                        cd_cnt <= cd_cnt - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_character_action_ctrl.sv
// Self-checking bench for character_action_ctrl: a tick-level behavioural
// model is compared against the DUT every clock, plus directed literal checks.

module tb_character_action_ctrl;

    localparam int X_MIN    = 0;
    localparam int X_MAX    = 576;
    localparam int X_START  = 100;
    localparam int STEP     = 2;
    localparam int FPA      = 4;
    localparam int ATK_FR   = 6;
    localparam int ACT_LO   = 2;
    localparam int ACT_HI   = 3;
    localparam int CD_TICKS = 8;

    localparam int S_IDLE = 0;
    localparam int S_WALK = 1;
    localparam int S_ATK  = 2;
    localparam int S_CD   = 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       move_l;
    logic       move_r;
    logic       attack;
    logic [9:0] pos_x;
    logic       facing;
    logic [1:0] state;
    logic [2:0] anim_frame;
    logic       attack_active;

    logic [9:0] pos_x2;
    logic       facing2;
    logic [1:0] state2;
    logic [2:0] anim_frame2;
    logic       attack_active2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    character_action_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .move_l(move_l), .move_r(move_r), .attack(attack),
        .pos_x(pos_x), .facing(facing), .state(state),
        .anim_frame(anim_frame), .attack_active(attack_active)
    );

    // Second instance starting one pixel short of the right edge.
    character_action_ctrl #(.X_START(10'd575)) dut_edge (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .move_l(move_l), .move_r(move_r), .attack(attack),
        .pos_x(pos_x2), .facing(facing2), .state(state2),
        .anim_frame(anim_frame2), .attack_active(attack_active2)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model (tick-count based) ----------------
    bit m_valid = 1'b0;
    int m_st;
    int m_pos;
    int m_face;
    int m_prev_att;
    int m_walk_n;   // ticks spent in WALK since entry
    int m_atk_n;    // ticks spent in ATTACK since entry
    int m_cd_left;  // lockout ticks remaining

    function automatic int exp_anim();
        if (m_st == S_WALK) return (m_walk_n / FPA) % 4;
        if (m_st == S_ATK)  return m_atk_n / FPA;
        return 0;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid    = 1'b1;
            m_st       = S_IDLE;
            m_pos      = X_START;
            m_face     = 0;
            m_prev_att = 0;
            m_walk_n   = 0;
            m_atk_n    = 0;
            m_cd_left  = 0;
        end else if (m_valid && frame_tick) begin
            bit rise;
            rise       = attack && (m_prev_att == 0);
            m_prev_att = int'(attack);
            case (m_st)
                S_IDLE, S_WALK: begin
                    if (rise) begin
                        m_st    = S_ATK;
                        m_atk_n = 0;
                    end else if (move_l != move_r) begin
                        if (m_st == S_WALK) m_walk_n++;
                        else m_walk_n = 0;
                        m_st   = S_WALK;
                        m_face = int'(move_l);
                        if (move_l) m_pos = (m_pos - STEP < X_MIN) ? X_MIN : m_pos - STEP;
                        else        m_pos = (m_pos + STEP > X_MAX) ? X_MAX : m_pos + STEP;
                    end else begin
                        m_st = S_IDLE;
                    end
                end
                S_ATK: begin
                    m_atk_n++;
                    if (m_atk_n == ATK_FR * FPA) begin
                        if (CD_TICKS == 0) m_st = S_IDLE;
                        else begin
                            m_st      = S_CD;
                            m_cd_left = CD_TICKS;
                        end
                    end
                end
                default: begin
                    m_cd_left--;
                    if (m_cd_left == 0) m_st = S_IDLE;
                end
            endcase
        end
    end

    // Compare DUT against the model on every falling edge once reset was seen.
    always @(negedge Clk) begin
        if (m_valid) begin
            int ea;
            ea = exp_anim();
            check("pos_x", 32'(pos_x), 32'(m_pos));
            check("facing", 32'(facing), 32'(m_face));
            check("state", 32'(state), 32'(m_st));
            check("anim_frame", 32'(anim_frame), 32'(ea));
            check("attack_active", 32'(attack_active),
                  32'((m_st == S_ATK) && ea >= ACT_LO && ea <= ACT_HI));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk) frame_tick = 1'b1;
            @(negedge Clk) frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset  = 1'b1;
        move_l = 1'b0;
        move_r = 1'b0;
        attack = 1'b0;
        @(negedge Clk) Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_atk;
        int n_act;
        int n_cd;
        Reset = 1'b1; frame_tick = 1'b0;
        move_l = 1'b0; move_r = 1'b0; attack = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // Reset state held with no ticks for 100 clocks.
        repeat (100) @(negedge Clk);
        check("rst_pos", 32'(pos_x), 32'd100);
        check("rst_state", 32'(state), 32'd0);
        check("rst_active", 32'(attack_active), 32'd0);
        check("edge_rst_pos", 32'(pos_x2), 32'd575);

        // Walk right 10 ticks then release.
        move_r = 1'b1;
        tick(1);
        check("edge_pos_1", 32'(pos_x2), 32'd576);
        tick(1);
        check("edge_pos_2", 32'(pos_x2), 32'd576);
        tick(8);
        check("walk_pos", 32'(pos_x), 32'd120);
        check("walk_state", 32'(state), 32'd1);
        check("walk_anim", 32'(anim_frame), 32'd2);
        move_r = 1'b0;
        tick(1);
        check("rel_state", 32'(state), 32'd0);
        check("rel_anim", 32'(anim_frame), 32'd0);
        check("rel_pos", 32'(pos_x), 32'd120);

        // Walk left into the left wall.
        do_reset();
        move_l = 1'b1;
        tick(49);
        check("left_pos49", 32'(pos_x), 32'd2);
        tick(1);
        check("left_pos50", 32'(pos_x), 32'd0);
        tick(10);
        check("left_pos60", 32'(pos_x), 32'd0);
        check("left_face", 32'(facing), 32'd1);

        // Walk right into the right wall.
        do_reset();
        move_r = 1'b1;
        tick(240);
        check("right_pos", 32'(pos_x), 32'd576);

        // Attack held with move_r: one attack, cooldown, then walking resumes.
        do_reset();
        move_r = 1'b1;
        attack = 1'b1;
        n_atk = 0; n_act = 0; n_cd = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (state == 2'd2) n_atk++;
            if (attack_active) n_act++;
            if (state == 2'd3) n_cd++;
            if (i == 24) check("atk_last_tick_state", 32'(state), 32'd2);
            if (i == 33) begin
                check("atk_idle_state", 32'(state), 32'd0);
                check("atk_frozen_pos", 32'(pos_x), 32'd100);
            end
        end
        check("atk_ticks", 32'(n_atk), 32'd24);
        check("act_ticks", 32'(n_act), 32'd8);
        check("cd_ticks", 32'(n_cd), 32'd8);
        check("atk_end_state", 32'(state), 32'd1);
        check("atk_end_pos", 32'(pos_x), 32'd114);

        // Both move keys, then attack edge together with move_l.
        do_reset();
        move_l = 1'b1;
        tick(1);
        move_r = 1'b1;
        tick(3);
        check("both_state", 32'(state), 32'd0);
        check("both_pos", 32'(pos_x), 32'd98);
        check("both_face", 32'(facing), 32'd1);
        move_r = 1'b0;
        attack = 1'b1;
        tick(1);
        check("atk_mv_state", 32'(state), 32'd2);
        check("atk_mv_pos", 32'(pos_x), 32'd98);

        // Tick held high for three clocks counts as three ticks.
        do_reset();
        move_r = 1'b1;
        @(negedge Clk) frame_tick = 1'b1;
        repeat (3) @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        check("long_tick_pos", 32'(pos_x), 32'd106);

        // Reset mid-attack, then keys held with no ticks.
        do_reset();
        attack = 1'b1;
        tick(9);
        @(negedge Clk);
        Reset      = 1'b1;
        frame_tick = 1'b1;
        @(negedge Clk);
        Reset      = 1'b0;
        frame_tick = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_anim", 32'(anim_frame), 32'd0);
        check("abort_pos", 32'(pos_x), 32'd100);
        move_r = 1'b1;
        repeat (50) @(negedge Clk);
        check("notick_state", 32'(state), 32'd0);
        check("notick_pos", 32'(pos_x), 32'd100);

        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
